// File: rtl/serial_parity_rx.sv
// Serial receiver for 8-bit frames with start, parity and stop bits, sampled on BitStrobe.
// Completed frames land in a single holding register with a valid/ack handshake and sticky overrun.
module serial_parity_rx #(
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic       MasterClock,
    input  logic       Reset,
    input  logic       BitStrobe,
    input  logic       SerIn,
    input  logic       RxAck,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Overrun,
    output logic [1:0] DbgState
);

    // Handshake: RxValid=1 means RxData/ParityErr/FrameErr hold an unconsumed byte;
    // the consumer takes it by driving RxAck=1 for one cycle while RxValid=1, and
    // RxValid drops on the next edge unless a new frame is loaded on that same edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    logic       load_ok;
    logic       load_drop;
    logic       frame_perr;

    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (BitStrobe) begin
            case (state_q)
                IDLE:    if (!SerIn) state_d = DATA;
                DATA:    if (cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-state datapath actions; nothing moves without a strobe.
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        load_ok   = 1'b0;
        load_drop = 1'b0;
        if (BitStrobe) begin
            case (state_q)
                IDLE: begin
                    if (!SerIn) cnt_d = 3'd0;
                end
                DATA: begin
                    shift_d = {SerIn, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                end
                PARITY: begin
                    par_d = SerIn;
                end
                STOP: begin
                    if (!rx_valid_q || RxAck) load_ok = 1'b1;
                    else                      load_drop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign frame_perr = ((^shift_q) ^ par_q) != ODD_PARITY;

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        if (load_ok) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            perr_d     = frame_perr;
            ferr_d     = ~SerIn;
        end else if (RxAck && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end
        // A fresh overrun in the same cycle as an ack keeps the flag set.
        if (RxAck)     ovr_d = 1'b0;
        if (load_drop) ovr_d = 1'b1;
    end

    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign RxData    = rx_data_q;
    assign RxValid   = rx_valid_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Overrun   = ovr_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: odd-parity instance plus an even-parity twin on the same line.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       BitStrobe = 1'b0;
    logic       SerIn = 1'b1;
    logic       RxAck = 1'b0;

    logic [7:0] o_data, e_data;
    logic       o_valid, e_valid;
    logic       o_perr, e_perr;
    logic       o_ferr, e_ferr;
    logic       o_ovr, e_ovr;
    logic [1:0] o_state, e_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.ODD_PARITY(1'b1)) u_odd (
        .MasterClock(clk), .Reset(Reset), .BitStrobe(BitStrobe), .SerIn(SerIn), .RxAck(RxAck),
        .RxData(o_data), .RxValid(o_valid), .ParityErr(o_perr), .FrameErr(o_ferr),
        .Overrun(o_ovr), .DbgState(o_state)
    );

    serial_parity_rx #(.ODD_PARITY(1'b0)) u_even (
        .MasterClock(clk), .Reset(Reset), .BitStrobe(BitStrobe), .SerIn(SerIn), .RxAck(RxAck),
        .RxData(e_data), .RxValid(e_valid), .ParityErr(e_perr), .FrameErr(e_ferr),
        .Overrun(e_ovr), .DbgState(e_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One strobed bit, then two idle (high, unstrobed) cycles; ends on a falling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        SerIn = b;
        BitStrobe = 1'b1;
        @(negedge clk);
        BitStrobe = 1'b0;
        SerIn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Frame bit 0 is start, bits 1..8 data LSB first, bit 9 parity, bit 10 stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_range(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(f[i]);
    endtask

    task automatic ack_pulse;
        @(negedge clk);
        RxAck = 1'b1;
        @(negedge clk);
        RxAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] f;

        // Reset
        #3 Reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_perr", o_perr, 1'b0);
        chk("rst_ferr", o_ferr, 1'b0);
        chk("rst_ovr", o_ovr, 1'b0);
        chk("rst_state", o_state, 2'd0);
        Reset = 1'b0;

        // Idle-high strobes never leave IDLE
        send_bit(1'b1);
        send_bit(1'b1);
        chk("idle_state", o_state, 2'd0);
        chk("idle_valid", o_valid, 1'b0);

        // 0xA5, parity 1, stop 1: latency of exactly one clock after the stop strobe
        f = mk_frame(8'hA5, 1'b1, 1'b1);
        send_range(f, 0, 9);
        chk("a5_state_stop", o_state, 2'd3);
        @(negedge clk);
        SerIn = 1'b1;
        BitStrobe = 1'b1;
        chk("a5_valid_pre", o_valid, 1'b0);
        @(negedge clk);
        BitStrobe = 1'b0;
        chk("a5_valid", o_valid, 1'b1);
        chk("a5_data", o_data, 8'hA5);
        chk("a5_perr", o_perr, 1'b0);
        chk("a5_ferr", o_ferr, 1'b0);
        chk("a5_even_perr", e_perr, 1'b1);
        chk("a5_state_idle", o_state, 2'd0);
        ack_pulse();
        chk("a5_ack_valid", o_valid, 1'b0);
        chk("a5_ack_data", o_data, 8'hA5);

        // 0xA5, parity 0: odd build flags it, even build accepts it
        send_range(mk_frame(8'hA5, 1'b0, 1'b1), 0, 10);
        chk("a5p0_data", o_data, 8'hA5);
        chk("a5p0_perr", o_perr, 1'b1);
        chk("a5p0_even_perr", e_perr, 1'b0);
        chk("a5p0_even_data", e_data, 8'hA5);
        ack_pulse();
        chk("a5p0_ack_perr_hold", o_perr, 1'b1);

        // 0x3C with a low stop bit is still delivered, then 0x01 resynchronises
        send_range(mk_frame(8'h3C, 1'b1, 1'b0), 0, 10);
        chk("3c_valid", o_valid, 1'b1);
        chk("3c_data", o_data, 8'h3C);
        chk("3c_ferr", o_ferr, 1'b1);
        chk("3c_perr", o_perr, 1'b0);
        ack_pulse();
        send_range(mk_frame(8'h01, 1'b0, 1'b1), 0, 10);
        chk("01_valid", o_valid, 1'b1);
        chk("01_data", o_data, 8'h01);
        chk("01_ferr", o_ferr, 1'b0);
        chk("01_perr", o_perr, 1'b0);
        ack_pulse();
        chk("01_ack_valid", o_valid, 1'b0);

        // Overrun: 0x11 pending, 0x22 dropped
        send_range(mk_frame(8'h11, 1'b1, 1'b1), 0, 10);
        chk("11_ovr_before", o_ovr, 1'b0);
        send_range(mk_frame(8'h22, 1'b1, 1'b0), 0, 10);
        chk("ovr_data_kept", o_data, 8'h11);
        chk("ovr_ferr_kept", o_ferr, 1'b0);
        chk("ovr_flag", o_ovr, 1'b1);
        chk("ovr_valid", o_valid, 1'b1);
        ack_pulse();
        chk("ovr_ack_valid", o_valid, 1'b0);
        chk("ovr_ack_flag", o_ovr, 1'b0);

        // Ack coincident with the load of 0x55 over pending 0x11
        send_range(mk_frame(8'h11, 1'b1, 1'b1), 0, 10);
        send_range(mk_frame(8'h55, 1'b1, 1'b1), 0, 9);
        @(negedge clk);
        SerIn = 1'b1;
        BitStrobe = 1'b1;
        RxAck = 1'b1;
        @(negedge clk);
        BitStrobe = 1'b0;
        RxAck = 1'b0;
        chk("55_data", o_data, 8'h55);
        chk("55_valid", o_valid, 1'b1);
        chk("55_ovr", o_ovr, 1'b0);

        // Ack with nothing pending changes nothing
        ack_pulse();
        ack_pulse();
        chk("idle_ack_valid", o_valid, 1'b0);
        chk("idle_ack_data", o_data, 8'h55);
        chk("idle_ack_ovr", o_ovr, 1'b0);

        // Leave 0x55 pending, then reset after 4 data bits of 0xFF
        send_range(mk_frame(8'h55, 1'b1, 1'b1), 0, 10);
        send_range(mk_frame(8'hFF, 1'b1, 1'b1), 0, 4);
        chk("ff_state_data", o_state, 2'd1);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("midrst_data", o_data, 8'h00);
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_state", o_state, 2'd0);
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst_valid", o_valid, 1'b0);
        send_range(mk_frame(8'h81, 1'b1, 1'b1), 0, 10);
        chk("81_data", o_data, 8'h81);
        chk("81_valid", o_valid, 1'b1);
        chk("81_perr", o_perr, 1'b0);
        ack_pulse();

        // 20 strobe-free cycles in the middle of 0x96 freeze the receiver
        f = mk_frame(8'h96, 1'b1, 1'b1);
        send_range(f, 0, 3);
        chk("96_state_pre", o_state, 2'd1);
        repeat (20) begin
            @(negedge clk);
            SerIn = 1'b0;
        end
        SerIn = 1'b1;
        chk("96_state_hold", o_state, 2'd1);
        chk("96_valid_hold", o_valid, 1'b0);
        send_range(f, 4, 10);
        chk("96_data", o_data, 8'h96);
        chk("96_valid", o_valid, 1'b1);
        chk("96_perr", o_perr, 1'b0);
        chk("96_ferr", o_ferr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
